lcd_i2c_cmd_queue: RTL and testbench
====================================

# lcd_i2c_cmd_queue

Queued HD44780 command/data sender for a 4-bit LCD behind a PCF8574 I2C expander, the parametrised successor of the single-shot LCD nibble sender. Callers push up to DEPTH commands (RS, byte, nibble-only flag) into an internal FIFO. The block expands each entry into expander bytes (E pulse per nibble) with microsecond-accurate gaps and inserts a long post-delay after clear/home. It sits between the LCD controller FSM and the I2C byte-write master.

## Interface
Parameters:
- CLK_MHZ, 12: clock cycles per microsecond.
- DEPTH, 4: FIFO entries, power of two, ≥2.
- SETUP_US, 10: gap after setup byte (E=0).
- PULSE_US, 10: gap after E=1 byte.
- HOLD_US, 50: gap after high-nibble E=0 byte, before low nibble.
- CMD_US, 50: post-delay after a normal command/data.
- LONG_US, 1600: post-delay after clear/home (RS=0, byte 0x01, 0x02 or 0x03).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_push  in  1  enqueue strobe.
- i_rs  in  1  register select of pushed entry.
- i_nibble_only  in  1  send high nibble only (init sequence).
- i_data  in  8  command/data byte.
- i_backlight  in  1  backlight level, sampled per byte.
- o_full  out  1  FIFO holds DEPTH entries.
- o_overflow  out  1  one-cycle pulse: push dropped.
- o_count  out  $clog2(DEPTH)+1  FIFO occupancy.
- o_busy  out  1  FIFO non-empty or sequencer not idle.
- o_i2c_valid  out  1  expander byte offered.
- o_i2c_data  out  8  expander byte.
- i_i2c_ready  in  1  I2C master accepts byte this cycle.

## Operation
- Expander byte: [7:4] nibble, [3] backlight, [2] E, [1] RW=0, [0] RS.
- Per nibble three bytes: setup (E=0), strobe (E=1), release (E=0). Full entry: high nibble then low nibble (6 bytes); nibble-only: 3 bytes.
- Gap after each acceptance: setup→SETUP_US, strobe→PULSE_US, high release→HOLD_US (or post-delay if nibble-only), low release→post-delay (LONG_US for clear/home with RS=0 and not nibble-only, else CMD_US).
- States: IDLE (pop head if count>0, phase=0) → SEND (valid high until ready) → DELAY (count gap) → SEND next phase, or IDLE after post-delay.
- Handshake: transfer when o_i2c_valid & i_i2c_ready. o_i2c_data stable while valid is high; backlight sampled when entering SEND.
- FIFO: push ignored when o_full (registered), even if a pop happens the same cycle; o_overflow pulses. Push with not full: entry written, count+1 next cycle. Simultaneous push and pop: count unchanged. Pointers wrap modulo DEPTH.

## Timing
- Reset (edge with i_rst_n=0): FIFO empty, state IDLE, all outputs 0 (o_i2c_data=0x00), o_count=0. In-flight entry and queued entries discarded; valid low after that edge.
- Push at edge t into an idle, empty block: pop at t+1, o_i2c_valid high from t+2.
- Gap N µs: with ready held high, consecutive acceptances exactly max(1, N·CLK_MHZ) cycles apart; o_i2c_valid low in between.
- o_busy falls max(1, post·CLK_MHZ) cycles after the final acceptance, unless the FIFO is non-empty; then the next entry's first byte is valid on the following cycle.
- Delay counter width sized for LONG_US·CLK_MHZ; no truncation.

## Test plan
- Push RS=1, 0x41, BL=1, ready=1 → bytes 0x49,0x4D,0x49,0x19,0x1D,0x19; acceptance spacings 120,120,600,120,120 cycles; o_busy low 600 cycles after last.
- Push RS=0, 0x01, BL=0 → 0x00,0x04,0x00,0x10,0x14,0x10; o_busy low 19200 cycles after last acceptance.
- Push RS=0, 0x30, nibble-only, BL=0 → 0x30,0x34,0x30 only; post-delay 600 cycles.
- Ready low for 5 cycles at the strobe byte → o_i2c_valid and 0x4D held stable 5 cycles; spacing restarts from actual acceptance.
- DEPTH=4: push 6 entries back-to-back while busy → o_count saturates at 4, o_full=1, o_overflow pulses twice, exactly 4 entries emitted in order.
- Assert i_rst_n=0 for one cycle mid-strobe → next cycle o_i2c_valid=0, o_count=0, o_busy=0; new push afterwards sends normally.

Source files
------------

// File: rtl/lcd_i2c_cmd_queue.sv
// lcd_i2c_cmd_queue: queued HD44780 4-bit command/data sender for a PCF8574 I2C expander.
// Rev 1.0 - FIFO of commands expanded into E-strobed expander bytes with timed gaps.
`default_nettype none

module lcd_i2c_cmd_queue #(
    parameter int CLK_MHZ  = 12,
    parameter int DEPTH    = 4,
    parameter int SETUP_US = 10,
    parameter int PULSE_US = 10,
    parameter int HOLD_US  = 50,
    parameter int CMD_US   = 50,
    parameter int LONG_US  = 1600
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_rs,
    input  logic                     i_nibble_only,
    input  logic [7:0]               i_data,
    input  logic                     i_backlight,
    output logic                     o_full,
    output logic                     o_overflow,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_busy,
    output logic                     o_i2c_valid,
    output logic [7:0]               o_i2c_data,
    input  logic                     i_i2c_ready
);

    function automatic int gap_cycles(input int us);
        int c;
        c = us * CLK_MHZ;
        return (c < 1) ? 1 : c;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int PW      = $clog2(DEPTH);
    localparam int CW      = PW + 1;
    localparam int G_SETUP = gap_cycles(SETUP_US);
    localparam int G_PULSE = gap_cycles(PULSE_US);
    localparam int G_HOLD  = gap_cycles(HOLD_US);
    localparam int G_CMD   = gap_cycles(CMD_US);
    localparam int G_LONG  = gap_cycles(LONG_US);
    localparam int G_MAX   = max2(max2(max2(G_SETUP, G_PULSE), max2(G_HOLD, G_CMD)), G_LONG);
    localparam int DW      = $clog2(G_MAX + 1);

    localparam logic [DW-1:0] GM_SETUP = DW'(G_SETUP - 1);
    localparam logic [DW-1:0] GM_PULSE = DW'(G_PULSE - 1);
    localparam logic [DW-1:0] GM_HOLD  = DW'(G_HOLD - 1);
    localparam logic [DW-1:0] GM_CMD   = DW'(G_CMD - 1);
    localparam logic [DW-1:0] GM_LONG  = DW'(G_LONG - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SEND  = 2'd1;
    localparam logic [1:0] S_DELAY = 2'd2;

    logic [1:0]    state, next_state;
    logic [9:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, push_ok, pop, accept, enter_send, is_last, last_q;
    logic [9:0]    head;
    logic          ent_rs, ent_nib;
    logic [7:0]    ent_data;
    logic [2:0]    phase, send_phase;
    logic [7:0]    byte_q, new_byte, src_data;
    logic          src_rs;
    logic [3:0]    nib;
    logic [DW-1:0] delay_cnt, gap_m1, post_m1;

    assign full    = (count == FULL_CNT);
    assign push_ok = i_push & ~full;
    assign pop     = (state == S_IDLE) && (count != '0);
    assign accept  = (state == S_SEND) && i_i2c_ready;
    assign head    = mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {i_rs, i_nibble_only, i_data};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
        end else begin
            o_overflow <= i_push & full;
            if (push_ok) wr_ptr <= PW'(wr_ptr + 1'b1);
            if (pop)     rd_ptr <= PW'(rd_ptr + 1'b1);
            case ({push_ok, pop})
                2'b10:   count <= CW'(count + 1'b1);
                2'b01:   count <= CW'(count - 1'b1);
                default: count <= count;
            endcase
        end
    end

    // Clear/home needs the long post-delay; nibble-only init writes never do.
    always_comb begin
        post_m1 = GM_CMD;
        if (!ent_rs && !ent_nib && (ent_data == 8'h01 || ent_data == 8'h02 || ent_data == 8'h03))
            post_m1 = GM_LONG;
        is_last = (phase == 3'd5) || (phase == 3'd2 && ent_nib);
        case (phase)
            3'd0, 3'd3: gap_m1 = GM_SETUP;
            3'd1, 3'd4: gap_m1 = GM_PULSE;
            3'd2:       gap_m1 = ent_nib ? post_m1 : GM_HOLD;
            default:    gap_m1 = post_m1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (count != '0) next_state = S_SEND;
            S_SEND: begin
                if (accept) begin
                    if (gap_m1 != '0) next_state = S_DELAY;
                    else              next_state = is_last ? S_IDLE : S_SEND;
                end
            end
            S_DELAY: if (delay_cnt == DW'(1)) next_state = last_q ? S_IDLE : S_SEND;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        o_i2c_valid = (state == S_SEND);
        o_busy      = (count != '0) || (state != S_IDLE);
        o_full      = full;
        o_count     = count;
        o_i2c_data  = byte_q;
    end

    // The byte for the next SEND is built from the FIFO head on a pop, else from the held entry.
    always_comb begin
        enter_send = (next_state == S_SEND) && ((state != S_SEND) || accept);
        if (state == S_IDLE)      send_phase = 3'd0;
        else if (state == S_SEND) send_phase = 3'(phase + 3'd1);
        else                      send_phase = phase;
        src_data = (state == S_IDLE) ? head[7:0] : ent_data;
        src_rs   = (state == S_IDLE) ? head[9]   : ent_rs;
        nib      = (send_phase < 3'd3) ? src_data[7:4] : src_data[3:0];
        new_byte = {nib, i_backlight, (send_phase == 3'd1 || send_phase == 3'd4), 1'b0, src_rs};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ent_rs    <= 1'b0;
            ent_nib   <= 1'b0;
            ent_data  <= 8'h00;
            phase     <= 3'd0;
            byte_q    <= 8'h00;
            delay_cnt <= '0;
            last_q    <= 1'b0;
        end else begin
            if (pop) begin
                ent_rs   <= head[9];
                ent_nib  <= head[8];
                ent_data <= head[7:0];
                phase    <= 3'd0;
            end
            if (accept) begin
                phase     <= 3'(phase + 3'd1);
                delay_cnt <= gap_m1;
                last_q    <= is_last;
            end else if (state == S_DELAY) begin
                delay_cnt <= DW'(delay_cnt - 1'b1);
            end
            if (enter_send) byte_q <= new_byte;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lcd_i2c_cmd_queue.sv
// tb_lcd_i2c_cmd_queue: directed checks of byte expansion, gap timing, FIFO limits and reset.
// Rev 1.0
`default_nettype none

module tb_lcd_i2c_cmd_queue;

    logic       clk = 1'b0;
    logic       rst_n, push, rs, nib_only, bl, ready;
    logic [7:0] data;
    logic       full, overflow, busy, valid;
    logic [2:0] count;
    logic [7:0] i2c_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0;
    int fall_cyc = 0;
    int ovf_cnt = 0;
    logic busy_prev = 1'b0;
    int   acc_cyc[$];
    logic [7:0] acc_byte[$];
    logic [7:0] exp6 [6];
    int   sp5 [5];
    logic [7:0] hi5 [5];
    logic [7:0] lo5 [5];

    lcd_i2c_cmd_queue dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_push       (push),
        .i_rs         (rs),
        .i_nibble_only(nib_only),
        .i_data       (data),
        .i_backlight  (bl),
        .o_full       (full),
        .o_overflow   (overflow),
        .o_count      (count),
        .o_busy       (busy),
        .o_i2c_valid  (valid),
        .o_i2c_data   (i2c_data),
        .i_i2c_ready  (ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Acceptance/busy monitor; an entry is tagged with the posedge it lands on.
    always @(negedge clk) begin
        #1;
        if (valid && ready) begin
            acc_cyc.push_back(cyc + 1);
            acc_byte.push_back(i2c_data);
        end
        if (overflow) ovf_cnt++;
        if (busy_prev && !busy) fall_cyc = cyc + 1;
        busy_prev = busy;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic do_push(input logic prs, input logic [7:0] pdata, input logic pnib);
        push = 1'b1; rs = prs; data = pdata; nib_only = pnib;
        tick();
        push = 1'b0;
    endtask

    task automatic wait_acc(input int n, input int budget);
        int k = 0;
        while (acc_byte.size() < n && k < budget) begin tick(); k++; end
        #2;
        check("acc_timeout", 32'(acc_byte.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin tick(); k++; end
        #2;
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (!valid && k < budget) begin tick(); k++; end
        check("valid_timeout", 32'(valid), 32'd1);
    endtask

    task automatic clear_mon();
        acc_cyc.delete();
        acc_byte.delete();
    endtask

    initial begin
        rst_n = 1'b0; push = 1'b0; rs = 1'b0; nib_only = 1'b0; data = 8'h00;
        bl = 1'b0; ready = 1'b0;
        repeat (3) tick();
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data", 32'(i2c_data), 32'h00);
        check("rst_count", 32'(count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        tick();

        // Data write 'A' with backlight
        clear_mon(); ready = 1'b1; bl = 1'b1;
        t0 = cyc + 1;
        do_push(1'b1, 8'h41, 1'b0);
        check("t1_count", 32'(count), 32'd1);
        wait_acc(6, 3000);
        wait_idle(2000);
        check("t1_latency", 32'(acc_cyc[0]), 32'(t0 + 2));
        exp6 = '{8'h49, 8'h4D, 8'h49, 8'h19, 8'h1D, 8'h19};
        for (int i = 0; i < 6; i++) check($sformatf("t1_byte%0d", i), 32'(acc_byte[i]), 32'(exp6[i]));
        sp5 = '{120, 120, 600, 120, 120};
        for (int i = 0; i < 5; i++) check($sformatf("t1_gap%0d", i), 32'(acc_cyc[i+1] - acc_cyc[i]), 32'(sp5[i]));
        check("t1_post", 32'(fall_cyc - acc_cyc[5]), 32'd600);
        check("t1_nbytes", 32'(acc_byte.size()), 32'd6);

        // Clear display: long post-delay
        clear_mon(); bl = 1'b0;
        do_push(1'b0, 8'h01, 1'b0);
        wait_acc(6, 3000);
        wait_idle(21000);
        exp6 = '{8'h00, 8'h04, 8'h00, 8'h10, 8'h14, 8'h10};
        for (int i = 0; i < 6; i++) check($sformatf("t2_byte%0d", i), 32'(acc_byte[i]), 32'(exp6[i]));
        check("t2_post", 32'(fall_cyc - acc_cyc[5]), 32'd19200);

        // Nibble-only init write
        clear_mon();
        do_push(1'b0, 8'h30, 1'b1);
        wait_acc(3, 2000);
        wait_idle(2000);
        check("t3_nbytes", 32'(acc_byte.size()), 32'd3);
        check("t3_b0", 32'(acc_byte[0]), 32'h30);
        check("t3_b1", 32'(acc_byte[1]), 32'h34);
        check("t3_b2", 32'(acc_byte[2]), 32'h30);
        check("t3_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'd120);
        check("t3_post", 32'(fall_cyc - acc_cyc[2]), 32'd600);

        // Ready stall on the strobe byte
        clear_mon(); ready = 1'b0; bl = 1'b1;
        do_push(1'b1, 8'h41, 1'b0);
        wait_valid(50);
        check("t4_setup", 32'(i2c_data), 32'h49);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        wait_valid(300);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t4_hold_v%0d", i), 32'(valid), 32'd1);
            check($sformatf("t4_hold_d%0d", i), 32'(i2c_data), 32'h4D);
            tick();
        end
        ready = 1'b1;
        wait_acc(6, 3000);
        wait_idle(2000);
        check("t4_gap_stall", 32'(acc_cyc[1] - acc_cyc[0]), 32'd125);
        check("t4_gap_after", 32'(acc_cyc[2] - acc_cyc[1]), 32'd120);
        check("t4_b2", 32'(acc_byte[2]), 32'h49);

        // FIFO saturation while the sequencer holds an entry
        clear_mon(); ovf_cnt = 0;
        do_push(1'b1, 8'h5F, 1'b0);
        tick();
        push = 1'b1; rs = 1'b1; nib_only = 1'b0;
        data = 8'hA1; tick();
        data = 8'hB2; tick();
        data = 8'hC3; tick();
        data = 8'hD4; tick();
        data = 8'hE5; tick();
        data = 8'hF6; tick();
        push = 1'b0;
        check("t5_count", 32'(count), 32'd4);
        check("t5_full", 32'(full), 32'd1);
        tick();
        check("t5_ovf_pulses", 32'(ovf_cnt), 32'd2);
        check("t5_ovf_low", 32'(overflow), 32'd0);
        wait_acc(30, 12000);
        wait_idle(2000);
        check("t5_nbytes", 32'(acc_byte.size()), 32'd30);
        hi5 = '{8'h59, 8'hA9, 8'hB9, 8'hC9, 8'hD9};
        lo5 = '{8'hF9, 8'h19, 8'h29, 8'h39, 8'h49};
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t5_hi%0d", i), 32'(acc_byte[6*i]), 32'(hi5[i]));
            check($sformatf("t5_lo%0d", i), 32'(acc_byte[6*i+3]), 32'(lo5[i]));
        end

        // Reset mid-strobe discards in-flight and queued entries
        clear_mon(); ready = 1'b0;
        do_push(1'b1, 8'h41, 1'b0);
        do_push(1'b1, 8'h42, 1'b0);
        do_push(1'b1, 8'h43, 1'b0);
        wait_valid(50);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        wait_valid(300);
        check("t6_pre_count", 32'(count), 32'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_valid", 32'(valid), 32'd0);
        check("t6_count", 32'(count), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        #2;
        clear_mon(); ready = 1'b1;
        tick();
        t0 = cyc + 1;
        do_push(1'b1, 8'h41, 1'b0);
        wait_acc(6, 3000);
        wait_idle(2000);
        check("t6_latency", 32'(acc_cyc[0]), 32'(t0 + 2));
        check("t6_nbytes", 32'(acc_byte.size()), 32'd6);
        exp6 = '{8'h49, 8'h4D, 8'h49, 8'h19, 8'h1D, 8'h19};
        for (int i = 0; i < 6; i++) check($sformatf("t6_byte%0d", i), 32'(acc_byte[i]), 32'(exp6[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
